// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory for the load/store stage: RV32/RV64 access sizes,
// request/response handshake, fault reporting and a self-initialising counting pattern.
module dmem_ctrl #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_BYTES = 64,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              init_busy
);

    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned WORDS = DEPTH_BYTES / NB;
    localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
    localparam int unsigned W_W   = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {StInit, StIdle, StResp} state_e;

    state_e          state_q, state_d;
    logic [W_W-1:0]  w_q, w_d;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;
    logic [7:0]      mem [DEPTH_BYTES];

    logic            accept;
    logic [3:0]      size_bytes;
    logic            legal, aligned, in_range, err;
    logic [ADDR_W:0] end_addr;
    logic [XLEN-1:0] raw, ld;

    // rst gates the handshake combinationally so a reset in RESP drops the response.
    assign req_ready  = (state_q == StIdle) && !rst;
    assign resp_valid = (state_q == StResp) && !rst;
    assign init_busy  = (state_q == StInit);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign accept     = req_valid && req_ready;

    always_comb begin
        size_bytes = 4'd1 << req_funct3[1:0];
        if (req_we) begin
            legal = (req_funct3 inside {3'b000, 3'b001, 3'b010}) ||
                    ((XLEN == 64) && (req_funct3 == 3'b011));
        end else begin
            legal = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                    ((XLEN == 64) && (req_funct3 inside {3'b011, 3'b110}));
        end
        case (req_funct3[1:0])
            2'b01:   aligned = !req_addr[0];
            2'b10:   aligned = (req_addr[1:0] == 2'b00);
            2'b11:   aligned = (req_addr[2:0] == 3'b000);
            default: aligned = 1'b1;
        endcase
        // One extra bit so addresses near the top of the space cannot wrap into range.
        end_addr = {1'b0, req_addr} + (ADDR_W+1)'(size_bytes) - (ADDR_W+1)'(1);
        in_range = end_addr < (ADDR_W+1)'(DEPTH_BYTES);
        err      = !(legal && aligned && in_range);
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < NB; i++) begin
            raw[8*i +: 8] = mem[req_addr[IDX_W-1:0] + IDX_W'(i)];
        end
        case (req_funct3)
            3'b000:  ld = XLEN'($signed(raw[7:0]));
            3'b001:  ld = XLEN'($signed(raw[15:0]));
            3'b010:  ld = XLEN'($signed(raw[31:0]));
            3'b100:  ld = XLEN'(raw[7:0]);
            3'b101:  ld = XLEN'(raw[15:0]);
            3'b110:  ld = XLEN'(raw[31:0]);
            default: ld = raw;
        endcase
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        unique case (state_q)
            StInit: begin
                if (w_q == W_W'(WORDS - 1)) begin
                    state_d = StIdle;
                    w_d     = '0;
                end else begin
                    w_d = w_q + W_W'(1);
                end
            end
            StIdle:  if (req_valid) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
            w_q     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            if (accept) begin
                err_q   <= err;
                rdata_q <= (err || req_we) ? '0 : ld;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StInit) begin
                for (int i = 0; i < NB; i++) begin
                    mem[IDX_W'(32'(w_q) * NB + i)] <= 8'(32'(w_q) * NB + i);
                end
            end else if (accept && req_we && !err) begin
                for (int i = 0; i < NB; i++) begin
                    if (4'(i) < size_bytes) begin
                        mem[req_addr[IDX_W-1:0] + IDX_W'(i)] <= req_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl at default parameters (XLEN=32, 64 bytes).
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        init_busy;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_D = 3'b011;
    localparam logic [2:0] F_BU = 3'b100, F_HU = 3'b101, F_BAD = 3'b111;

    dmem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .init_busy  (init_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, starting and ending on a falling edge (ends in the RESP cycle).
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("resp_valid_pulse", {31'b0, resp_valid}, 32'd1);
        rd = resp_rdata;
        er = resp_err;
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] exp);
        logic [31:0] rd;
        logic        er;
        do_req(1'b0, f3, addr, 32'h0, rd, er);
        check({tag, "_data"}, rd, exp);
        check({tag, "_err"}, {31'b0, er}, 32'd0);
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        logic        er;
        do_req(1'b1, f3, addr, wd, rd, er);
        check("store_err", {31'b0, er}, 32'd0);
    endtask

    task automatic fault(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr);
        logic [31:0] rd;
        logic        er;
        do_req(we, f3, addr, 32'hFFFF_FFFF, rd, er);
        check({tag, "_err"}, {31'b0, er}, 32'd1);
        check({tag, "_data"}, rd, 32'h0);
    endtask

    // Count falling edges until init_busy drops; any resp_valid seen meanwhile is stray.
    task automatic wait_init(input string tag);
        int n = 0;
        int stray = 0;
        do begin
            @(negedge clk);
            n++;
            if (resp_valid) stray++;
        end while (init_busy && n < 100);
        check({tag, "_cycles"}, n, 32'd16);
        check({tag, "_stray_resp"}, stray, 32'd0);
    endtask

    initial begin
        int readies, pulses, bad;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = F_W; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_init_busy", {31'b0, init_busy}, 32'd1);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);

        // Request held through INIT must wait until the sweep is done.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F_W; req_addr = 32'h0;
        rst = 1'b0;
        wait_init("init");
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("init_lw0_valid", {31'b0, resp_valid}, 32'd1);
        check("init_lw0_data", resp_rdata, 32'h0302_0100);
        load("init_lw3c", F_W, 32'h3C, 32'h3F3E_3D3C);

        store(F_W, 32'h10, 32'h80FF_7F01);
        load("lb_11", F_B, 32'h11, 32'h0000_007F);
        load("lb_12", F_B, 32'h12, 32'hFFFF_FFFF);
        load("lbu_12", F_BU, 32'h12, 32'h0000_00FF);
        load("lh_12", F_H, 32'h12, 32'hFFFF_80FF);
        load("lhu_12", F_HU, 32'h12, 32'h0000_80FF);

        store(F_B, 32'h21, 32'h0000_00AA);
        store(F_H, 32'h22, 32'h0000_BEEF);
        load("partial_lw20", F_W, 32'h20, 32'hBEEF_AA20);

        fault("lw_misaligned", 1'b0, F_W, 32'h2);
        fault("sw_misaligned", 1'b1, F_W, 32'h2);
        load("after_sw_mis", F_W, 32'h0, 32'h0302_0100);
        fault("lh_misaligned", 1'b0, F_H, 32'h3F);
        fault("sw_range", 1'b1, F_W, 32'h40);
        fault("lw_wrap", 1'b0, F_W, 32'hFFFF_FFFC);
        fault("ld_rv32", 1'b0, F_D, 32'h8);
        fault("sd_rv32", 1'b1, F_D, 32'h8);
        fault("bad_f3", 1'b0, F_BAD, 32'h0);
        load("after_sd", F_W, 32'h8, 32'h0B0A_0908);
        load("top_word", F_W, 32'h3C, 32'h3F3E_3D3C);
        load("top_byte", F_B, 32'h3F, 32'h0000_003F);

        // Held request: ready and resp_valid must alternate every cycle.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = F_W; req_addr = 32'h4;
        readies = 0; pulses = 0; bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            readies += int'(req_ready);
            pulses  += int'(resp_valid);
            if (req_ready == resp_valid) bad++;
        end
        req_valid = 1'b0;
        check("hs_accepts", readies, 32'd4);
        check("hs_pulses", pulses, 32'd4);
        check("hs_alternate", bad, 32'd0);
        check("hs_data", resp_rdata, 32'h0706_0504);

        // Reset in the RESP cycle of a store.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F_W; req_addr = 32'h0;
        req_wdata = 32'hDEAD_BEEF;
        begin
            int n = 0;
            while (!req_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        req_valid = 1'b0;
        check("rst_resp_dropped", {31'b0, resp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst2_init_busy", {31'b0, init_busy}, 32'd1);
        rst = 1'b0;
        wait_init("reinit");
        load("reinit_lw0", F_W, 32'h0, 32'h0302_0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
